// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops
// reset to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      dout     <= 1'b1;
    end else begin
      meta_reg <= din;
      dout     <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start / Word_Len data bits (LSB first) / optional even parity / stop,
// with valid/ready output and frame/overrun error pulses. Parity via `UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int Word_Len  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Uart_Rx,
  output logic [Word_Len-1:0] rx_data_out,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                frame_err,
  output logic                overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(Word_Len + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(Word_Len - 1);

  logic                rx_sync;
  uart_state_t         state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [BW-1:0]       bit_reg, bit_next;
  logic [Word_Len-1:0] shift_reg, shift_next;
  logic                sample;
  logic                word_done;
  logic                frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                parity_bad;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (Uart_Rx),
    .dout  (rx_sync)
  );

  assign sample = (cnt_reg == BIT_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    word_done  = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_sync) begin
          state_next = START;
          bit_next   = '0;
        end
      end
      START: begin
        // A start bit must still be low at its centre, otherwise it was a glitch.
        if (cnt_reg == HALF_END) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_next = {rx_sync, shift_reg[Word_Len-1:1]};
          bit_next   = bit_reg + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_reg == LAST_BIT) state_next = PARITY;
`else
          if (bit_reg == LAST_BIT) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          if ((^shift_reg) != rx_sync) begin
            parity_bad = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (sample) begin
          state_next = IDLE;
          word_done  = rx_sync;
          frame_bad  = !rx_sync;
        end
      end
      default: state_next = IDLE;
    endcase
    // Counter restarts on every state change and at each in-state data sample.
    if (state_next != state_reg || state_reg == IDLE || (state_reg == DATA && sample))
      cnt_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_out   <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      frame_err   <= frame_bad;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= parity_bad;
`endif
      if (word_done) begin
        rx_data_out   <= shift_reg;
        rx_data_valid <= 1'b1;
        overrun_err   <= rx_data_valid && !rx_data_ready;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, random frames
// against a frame-level reference model, and hand sequences for corner cases.
module tb_uart_receiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int WL        = 8;
  localparam int B         = CLK_FREQ / BAUD_RATE;

  logic          clk = 1'b0;
  logic          reset;
  logic          uart_rx;
  logic          rx_data_ready;
  logic [WL-1:0] rx_data_out;
  logic          rx_data_valid;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  int checks = 0;
  int errors = 0;

  // Monitor tallies (sampled mid-cycle).
  int            n_words = 0, valid_cycles = 0, n_frame = 0, n_ovr = 0, n_par = 0;
  logic [WL-1:0] got_q[$];

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .Word_Len(WL)) dut (
    .clk           (clk),
    .reset         (reset),
    .Uart_Rx       (uart_rx),
    .rx_data_out   (rx_data_out),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err    (parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_data_valid) valid_cycles++;
      if (rx_data_valid && rx_data_ready) begin
        n_words++;
        got_q.push_back(rx_data_out);
      end
      if (frame_err) n_frame++;
      if (overrun_err) n_ovr++;
      if (parity_err) n_par++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one frame; a bad stop bit is held low through its centre only.
  task automatic send_frame(input logic [WL-1:0] d, input bit stop_ok, input bit par_bad);
    uart_rx = 1'b0;
    tick(B);
    for (int i = 0; i < WL; i++) begin
      uart_rx = d[i];
      tick(B);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ par_bad;
    tick(B);
`endif
    if (stop_ok) begin
      uart_rx = 1'b1;
      tick(B);
    end else begin
      uart_rx = 1'b0;
      tick(3 * B / 4);
      uart_rx = 1'b1;
      tick(B - 3 * B / 4);
    end
    uart_rx = 1'b1;
  endtask

  // One frame with ready held high, then compare every observable tally.
  task automatic run_txn(input string nm, input logic [WL-1:0] d, input bit stop_ok,
                         input bit par_bad, input int exp_words, input logic [WL-1:0] exp_word,
                         input int exp_frame, input int exp_par);
    int w0, v0, f0, o0, p0;
    w0 = n_words; v0 = valid_cycles; f0 = n_frame; o0 = n_ovr; p0 = n_par;
    send_frame(d, stop_ok, par_bad);
    tick(2 * B);
    chk({nm, ".words"}, n_words - w0, exp_words);
    chk({nm, ".valid_cycles"}, valid_cycles - v0, exp_words);
    if (exp_words > 0) chk({nm, ".data"}, got_q[$], exp_word);
    chk({nm, ".frame_err"}, n_frame - f0, exp_frame);
    chk({nm, ".overrun_err"}, n_ovr - o0, 0);
    chk({nm, ".parity_err"}, n_par - p0, exp_par);
    $display("TXN %s data=%02h stop_ok=%0d par_bad=%0d words=%0d frame=%0d par=%0d",
             nm, d, stop_ok, par_bad, n_words - w0, n_frame - f0, n_par - p0);
  endtask

  typedef struct {
    logic [WL-1:0] data;
    bit            stop_ok;
    int            exp_words;
    logic [WL-1:0] exp_word;
    int            exp_frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            w0, f0, o0;
    logic [WL-1:0] d;
    bit            stop_ok, par_bad;
    int            ew, ef, ep;

    vecs[0] = '{8'h4A, 1'b1, 1, 8'h4A, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[4] = '{8'h81, 1'b0, 0, 8'h00, 1};
    vecs[5] = '{8'hA5, 1'b1, 1, 8'hA5, 0};

    reset = 1'b1;
    uart_rx = 1'b1;
    rx_data_ready = 1'b1;
    tick(3);
    chk("reset.valid", rx_data_valid, 0);
    chk("reset.data", rx_data_out, 0);
    chk("reset.frame_err", frame_err, 0);
    chk("reset.overrun_err", overrun_err, 0);
    reset = 1'b0;
    tick(B);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, 1'b0,
              vecs[i].exp_words, vecs[i].exp_word, vecs[i].exp_frame, 0);

    // Random frames against a frame-level model: a parity error discards the
    // word, otherwise the stop bit decides between delivery and frame error.
    for (int i = 0; i < 16; i++) begin
      d = WL'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad = stop_ok && ($urandom_range(0, 3) == 0);
`endif
      ep = par_bad ? 1 : 0;
      ew = (!par_bad && stop_ok) ? 1 : 0;
      ef = (!par_bad && !stop_ok) ? 1 : 0;
      run_txn($sformatf("rnd%0d", i), d, stop_ok, par_bad, ew, d, ef, ep);
    end

    // Overrun: two words with the consumer stalled.
    rx_data_ready = 1'b0;
    w0 = n_words; f0 = n_frame; o0 = n_ovr;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(2 * B);
    chk("ovr.first_valid", rx_data_valid, 1);
    chk("ovr.first_data", rx_data_out, 8'h55);
    chk("ovr.first_no_ovr", n_ovr - o0, 0);
    send_frame(8'hA3, 1'b1, 1'b0);
    tick(2 * B);
    chk("ovr.second_valid", rx_data_valid, 1);
    chk("ovr.second_data", rx_data_out, 8'hA3);
    chk("ovr.pulse", n_ovr - o0, 1);
    chk("ovr.frame_err", n_frame - f0, 0);
    rx_data_ready = 1'b1;
    tick(2);
    chk("ovr.valid_cleared", rx_data_valid, 0);
    chk("ovr.words", n_words - w0, 1);
    chk("ovr.delivered", got_q[$], 8'hA3);
    $display("TXN overrun 55,A3 words=%0d ovr=%0d", n_words - w0, n_ovr - o0);

    // Start glitch shorter than half a bit.
    w0 = n_words; f0 = n_frame; o0 = n_ovr;
    uart_rx = 1'b0;
    tick(B / 4);
    uart_rx = 1'b1;
    tick(3 * B);
    chk("glitch.words", n_words - w0, 0);
    chk("glitch.valid", rx_data_valid, 0);
    chk("glitch.frame_err", n_frame - f0, 0);
    chk("glitch.overrun_err", n_ovr - o0, 0);
    $display("TXN glitch words=%0d frame=%0d", n_words - w0, n_frame - f0);
    run_txn("after_glitch", 8'h96, 1'b1, 1'b0, 1, 8'h96, 0, 0);

    // Back-to-back frames with no idle gap.
    w0 = n_words;
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2 * B);
    chk("b2b.words", n_words - w0, 2);
    chk("b2b.first", got_q[$-1], 8'h5A);
    chk("b2b.second", got_q[$], 8'hC3);
    $display("TXN back_to_back 5A,C3 words=%0d", n_words - w0);

    // Reset during data bit 4 of 0xFF while a word is still pending.
    rx_data_ready = 1'b0;
    send_frame(8'hE7, 1'b1, 1'b0);
    tick(2 * B);
    chk("rst.pending_valid", rx_data_valid, 1);
    w0 = n_words; f0 = n_frame;
    uart_rx = 1'b0;
    tick(B);
    uart_rx = 1'b1;
    tick(4 * B + B / 2);
    reset = 1'b1;
    #1;
    chk("rst.async_valid", rx_data_valid, 0);
    chk("rst.async_data", rx_data_out, 0);
    tick(2);
    reset = 1'b0;
    rx_data_ready = 1'b1;
    tick(B);
    run_txn("after_reset", 8'h12, 1'b1, 1'b0, 1, 8'h12, 0, 0);
    chk("rst.only_new_word", n_words - w0, 1);
    chk("rst.frame_err", n_frame - f0, 0);
    $display("TXN reset_mid_frame words=%0d last=%02h", n_words - w0, got_q[$]);

`ifdef UART_RX_PARITY_EN
    run_txn("par_bad_07", 8'h07, 1'b1, 1'b1, 0, 8'h00, 0, 1);
    run_txn("par_ok_07", 8'h07, 1'b1, 1'b0, 1, 8'h07, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
